mic_buffer_writer: RTL and testbench
====================================

MIC_BUFFER_WRITER -- requirements
Module: mic_buffer_writer

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, the number of mic channels; it SHALL be a power of 2.
REQ-002 SHALL have parameter SAMPLE_BITS, default 7, where log2 of samples per channel per bank is 7, giving 128 samples.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, the PCM sample width.
REQ-004 SHALL derive CH_BITS = log2(CHANNELS) and ADDR_WIDTH = 1 + SAMPLE_BITS + CH_BITS.
REQ-005 SHALL have the following ports:
- clk  in  1  the only clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  capture enable
- pcm_valid  in  1  one-cycle sample strobe from the decimator
- pcm_channel  in  CH_BITS  channel index of pcm_data
- pcm_data  in  DATA_WIDTH  sample
- irq_ack  in  1  host acknowledge of the completed bank
- buf_we  out  1  buffer write enable
- buf_adr  out  ADDR_WIDTH  buffer write address
- buf_dat  out  DATA_WIDTH  buffer write data
- irq  out  1  level; a bank is ready
- ready_bank  out  1  index of the last completed bank
- overflow  out  1  sticky; a bank completed while irq was unacknowledged
- frame_err  out  1  sticky; channel sequence violation

Function
REQ-006 SHALL compute buf_adr as {bank, sample_idx, channel}, with bank at the MSB and channel at the LSBs.
REQ-007 SHALL assert buf_we, buf_adr and buf_dat registered exactly 1 cycle after an accepted pcm_valid; buf_we SHALL be low otherwise.
REQ-008 SHALL implement an FSM with states IDLE, SYNC and FILL.
REQ-009 IDLE transitions:
- entered whenever enable=0
- all samples dropped
- bank, sample_idx and expected channel held at 0
- enable=1 transitions to SYNC
REQ-010 SYNC transitions:
- pcm_valid with pcm_channel≠0 is dropped
- pcm_valid with pcm_channel=0 is written, expected channel becomes 1, and the FSM goes to FILL
REQ-011 FILL transitions:
- pcm_valid with pcm_channel equal to the expected channel is written and the expected channel increments
- after channel CHANNELS-1, expected channel wraps to 0 and sample_idx increments
REQ-012 In FILL, pcm_valid with an unexpected pcm_channel SHALL set frame_err, drop the sample, leave sample_idx unchanged and return the FSM to SYNC.
REQ-013 Bank completion is the write of channel CHANNELS-1 at sample_idx=2^SAMPLE_BITS-1; on completion, in the same cycle as buf_we:
- ready_bank <= bank
- bank toggles
- sample_idx wraps to 0
- irq <= 1
REQ-014 The writer SHALL never stall; the next bank is overwritten regardless of host state.
REQ-015 Completion while irq=1 and irq_ack=0 SHALL set overflow; irq stays 1.
REQ-016 irq_ack=1 SHALL clear irq on the next edge unless a completion occurs in the same cycle, in which case irq stays 1 and overflow is not set.
REQ-017 enable falling mid-bank SHALL return the FSM to IDLE next cycle and discard the partial bank.
REQ-018 overflow and frame_err SHALL clear on IDLE entry, and irq SHALL also clear on IDLE entry.
REQ-019 pcm_valid in the cycle enable drops SHALL be dropped.

Reset
REQ-020 rst SHALL force the FSM to IDLE, bank/sample_idx/channel counters to 0, and all outputs to 0: buf_we, buf_adr, buf_dat, irq, ready_bank, overflow, frame_err, and ovf_count when present.
REQ-021 rst SHALL take priority over all other inputs.

Configuration
REQ-022 With macro MIC_BUF_OVFCNT_EN defined, the block SHALL add output ovf_count [15:0].
- ovf_count increments on each event that sets or would set overflow, saturating at 16'hFFFF.
- ovf_count clears on rst or IDLE entry.
REQ-023 Without MIC_BUF_OVFCNT_EN, the port and counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (IDLE=0, SYNC=1, FILL=2, 2 bits) and the address-field offset constants.
REQ-025 The address/sequence counter (channel, sample_idx, bank) SHALL be one sub-module, mic_buffer_addr_cnt; the FSM and irq logic stay in the top.

Verification (CHANNELS=8, SAMPLE_BITS=2, DATA_WIDTH=16)
REQ-026 rst then enable, 32 in-order samples with data = 0x100+n:
- writes occur to adr 0..31
- on the 32nd write: irq=1, ready_bank=0, bank becomes 1
REQ-027 After REQ-026 with no irq_ack, 32 more samples:
- adr 32..63 written, then 0.. on wrap
- on the 2nd completion: overflow=1, ready_bank=1, ovf_count=1 when the macro is defined
REQ-028 Ack-on-completion: irq_ack pulsed in the exact cycle of the 2nd completion:
- irq stays 1
- overflow stays 0
REQ-029 Channel glitch: sequence 0,1,2,5 at sample 0:
- frame_err=1
- channel 5 not written
- further samples dropped until channel 0
- the next channel 0 is written at adr 0
REQ-030 Enable drop after 13 writes:
- the FSM goes to IDLE
- irq, overflow and frame_err read 0
- re-enable restarts writing at adr 0
REQ-031 rst asserted mid-bank with pcm_valid=1: all outputs are 0 on the next edge and no buf_we is produced.

Source files
------------

// File: rtl/mic_buffer_writer_pkg.sv
// Shared definitions for the mic buffer writer: FSM state encoding and
// the bit offsets of the channel / sample / bank fields in the buffer address.
// Latency: n/a. Backpressure: n/a.
package mic_buffer_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        FILL = 2'd2
    } state_t;

    // Address layout is {bank, sample_idx, channel}; channel sits at the LSBs.
    localparam int CH_LSB = 0;

    function automatic int samp_lsb(input int ch_bits);
        return ch_bits;
    endfunction

    function automatic int bank_lsb(input int ch_bits, input int sample_bits);
        return ch_bits + sample_bits;
    endfunction

endpackage

// File: rtl/mic_buffer_addr_cnt.sv
// Address/sequence counter: expected channel, sample index within bank, bank.
// Latency: counters update on the edge after adv; last_slot is combinational.
// Backpressure: none; advances unconditionally whenever adv is high.
// Ports: clr zeroes everything (IDLE), ch_clr zeroes only the channel (resync),
//        adv steps to the next slot; ch/samp_idx/bank/last_slot report position.
module mic_buffer_addr_cnt
    import mic_buffer_writer_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int SAMPLE_BITS = 7,
    localparam int CH_BITS    = $clog2(CHANNELS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   ch_clr,
    input  logic                   adv,
    output logic [CH_BITS-1:0]     ch,
    output logic [SAMPLE_BITS-1:0] samp_idx,
    output logic                   bank,
    output logic                   last_slot
);

    localparam logic [CH_BITS-1:0]     CH_MAX   = CH_BITS'(CHANNELS - 1);
    localparam logic [SAMPLE_BITS-1:0] SAMP_MAX = '1;

    logic [CH_BITS-1:0]     ch_q, ch_d;
    logic [SAMPLE_BITS-1:0] samp_q, samp_d;
    logic                   bank_q, bank_d;

    always_comb begin
        ch_d   = ch_q;
        samp_d = samp_q;
        bank_d = bank_q;
        if (clr) begin
            ch_d   = '0;
            samp_d = '0;
            bank_d = 1'b0;
        end else if (ch_clr) begin
            // A sequence error restarts the current sample slot at channel 0.
            ch_d = '0;
        end else if (adv) begin
            if (ch_q == CH_MAX) begin
                ch_d = '0;
                if (samp_q == SAMP_MAX) begin
                    samp_d = '0;
                    bank_d = ~bank_q;
                end else begin
                    samp_d = samp_q + SAMPLE_BITS'(1);
                end
            end else begin
                ch_d = ch_q + CH_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q   <= '0;
            samp_q <= '0;
            bank_q <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            samp_q <= samp_d;
            bank_q <= bank_d;
        end
    end

    assign ch        = ch_q;
    assign samp_idx  = samp_q;
    assign bank      = bank_q;
    assign last_slot = (ch_q == CH_MAX) && (samp_q == SAMP_MAX);

endmodule

// File: rtl/mic_buffer_writer.sv
// Writes interleaved PCM samples into a double-banked buffer, raises irq per bank.
// Latency: buf_we/buf_adr/buf_dat are registered 1 cycle after an accepted pcm_valid.
// Backpressure: none; never stalls, overwrites the next bank regardless of the host.
// Ports: pcm_* sample stream in; buf_* buffer write port out; irq/irq_ack/ready_bank
//        host handshake; overflow and frame_err are sticky until the FSM re-enters IDLE.
// Optional: MIC_BUF_OVFCNT_EN adds ovf_count, a saturating overflow-event counter.
module mic_buffer_writer
    import mic_buffer_writer_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int SAMPLE_BITS = 7,
    parameter int DATA_WIDTH  = 16,
    localparam int CH_BITS    = $clog2(CHANNELS),
    localparam int ADDR_WIDTH = 1 + SAMPLE_BITS + CH_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  pcm_valid,
    input  logic [CH_BITS-1:0]    pcm_channel,
    input  logic [DATA_WIDTH-1:0] pcm_data,
    input  logic                  irq_ack,
    output logic                  buf_we,
    output logic [ADDR_WIDTH-1:0] buf_adr,
    output logic [DATA_WIDTH-1:0] buf_dat,
    output logic                  irq,
    output logic                  ready_bank,
    output logic                  overflow,
    output logic                  frame_err
`ifdef MIC_BUF_OVFCNT_EN
    ,
    output logic [15:0]           ovf_count
`endif
);

    localparam int SAMP_LSB = samp_lsb(CH_BITS);
    localparam int BANK_LSB = bank_lsb(CH_BITS, SAMPLE_BITS);

    state_t                  state_q, state_d;
    logic                    buf_we_q, buf_we_d;
    logic [ADDR_WIDTH-1:0]   buf_adr_q, buf_adr_d;
    logic [DATA_WIDTH-1:0]   buf_dat_q, buf_dat_d;
    logic                    irq_q, irq_d;
    logic                    ready_bank_q, ready_bank_d;
    logic                    overflow_q, overflow_d;
    logic                    frame_err_q, frame_err_d;

    logic                    accept;
    logic                    frame_bad;
    logic                    idle_d;
    logic                    complete;
    logic                    ovf_evt;
    logic [CH_BITS-1:0]      cnt_ch;
    logic [SAMPLE_BITS-1:0]  cnt_samp;
    logic                    cnt_bank;
    logic                    cnt_last;

    mic_buffer_addr_cnt #(
        .CHANNELS    (CHANNELS),
        .SAMPLE_BITS (SAMPLE_BITS)
    ) u_addr_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (idle_d),
        .ch_clr    (frame_bad),
        .adv       (accept),
        .ch        (cnt_ch),
        .samp_idx  (cnt_samp),
        .bank      (cnt_bank),
        .last_slot (cnt_last)
    );

    // Next-state: enable low always lands in IDLE, which also drops any
    // pcm_valid arriving in that same cycle.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        frame_bad = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = SYNC;
            end
            SYNC: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (pcm_valid && (pcm_channel == '0)) begin
                    accept  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (pcm_valid) begin
                    if (pcm_channel == cnt_ch) begin
                        accept = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = SYNC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idle_d   = (state_d == IDLE);
    assign complete = accept && cnt_last;
    // An ack landing in the completion cycle absorbs the new completion.
    assign ovf_evt  = complete && irq_q && !irq_ack;

    always_comb begin
        buf_we_d     = accept;
        buf_adr_d    = buf_adr_q;
        buf_dat_d    = buf_dat_q;
        irq_d        = irq_q;
        ready_bank_d = ready_bank_q;
        overflow_d   = overflow_q;
        frame_err_d  = frame_err_q;

        if (accept) begin
            buf_adr_d[CH_LSB +: CH_BITS]       = pcm_channel;
            buf_adr_d[SAMP_LSB +: SAMPLE_BITS] = cnt_samp;
            buf_adr_d[BANK_LSB]                = cnt_bank;
            buf_dat_d                          = pcm_data;
        end
        if (complete) ready_bank_d = cnt_bank;

        if (idle_d) begin
            irq_d       = 1'b0;
            overflow_d  = 1'b0;
            frame_err_d = 1'b0;
        end else begin
            if (complete)     irq_d = 1'b1;
            else if (irq_ack) irq_d = 1'b0;
            if (ovf_evt)   overflow_d  = 1'b1;
            if (frame_bad) frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            buf_we_q     <= 1'b0;
            buf_adr_q    <= '0;
            buf_dat_q    <= '0;
            irq_q        <= 1'b0;
            ready_bank_q <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_we_q     <= buf_we_d;
            buf_adr_q    <= buf_adr_d;
            buf_dat_q    <= buf_dat_d;
            irq_q        <= irq_d;
            ready_bank_q <= ready_bank_d;
            overflow_q   <= overflow_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign buf_we     = buf_we_q;
    assign buf_adr    = buf_adr_q;
    assign buf_dat    = buf_dat_q;
    assign irq        = irq_q;
    assign ready_bank = ready_bank_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

`ifdef MIC_BUF_OVFCNT_EN
    logic [15:0] ovf_count_q, ovf_count_d;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (idle_d) begin
            ovf_count_d = '0;
        end else if (ovf_evt && (ovf_count_q != 16'hFFFF)) begin
            ovf_count_d = ovf_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_count_q <= '0;
        else     ovf_count_q <= ovf_count_d;
    end

    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_mic_buffer_writer.sv
// Directed bench for mic_buffer_writer with CHANNELS=8, SAMPLE_BITS=2 (32 slots/bank).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mic_buffer_writer;

    localparam int CHANNELS    = 8;
    localparam int SAMPLE_BITS = 2;
    localparam int DATA_WIDTH  = 16;
    localparam int CH_BITS     = 3;
    localparam int ADDR_WIDTH  = 6;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic                  pcm_valid;
    logic [CH_BITS-1:0]    pcm_channel;
    logic [DATA_WIDTH-1:0] pcm_data;
    logic                  irq_ack;
    logic                  buf_we;
    logic [ADDR_WIDTH-1:0] buf_adr;
    logic [DATA_WIDTH-1:0] buf_dat;
    logic                  irq;
    logic                  ready_bank;
    logic                  overflow;
    logic                  frame_err;
`ifdef MIC_BUF_OVFCNT_EN
    logic [15:0]           ovf_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mic_buffer_writer #(
        .CHANNELS    (CHANNELS),
        .SAMPLE_BITS (SAMPLE_BITS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pcm_valid   (pcm_valid),
        .pcm_channel (pcm_channel),
        .pcm_data    (pcm_data),
        .irq_ack     (irq_ack),
        .buf_we      (buf_we),
        .buf_adr     (buf_adr),
        .buf_dat     (buf_dat),
        .irq         (irq),
        .ready_bank  (ready_bank),
        .overflow    (overflow),
        .frame_err   (frame_err)
`ifdef MIC_BUF_OVFCNT_EN
        ,
        .ovf_count   (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given stimulus; returns at posedge+1.
    task automatic cycle(input logic v, input int ch, input int dat, input logic ack);
        pcm_valid   = v;
        pcm_channel = CH_BITS'(ch);
        pcm_data    = DATA_WIDTH'(dat);
        irq_ack     = ack;
        @(posedge clk);
        #1;
        pcm_valid = 1'b0;
        irq_ack   = 1'b0;
    endtask

    task automatic wr(input int ch, input int dat, input int adr, input logic ack);
        cycle(1'b1, ch, dat, ack);
        chk("we", 32'(buf_we), 32'd1);
        chk("adr", 32'(buf_adr), 32'(adr));
        chk("dat", 32'(buf_dat), 32'(dat));
    endtask

    task automatic drop(input int ch, input string tag);
        cycle(1'b1, ch, 16'h0BAD, 1'b0);
        chk(tag, 32'(buf_we), 32'd0);
    endtask

    task automatic chk_flags(input string tag, input int e_irq, input int e_ovf, input int e_ferr);
        chk({tag, "_irq"},  32'(irq),       32'(e_irq));
        chk({tag, "_ovf"},  32'(overflow),  32'(e_ovf));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(e_ferr));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; pcm_valid = 1'b0;
        pcm_channel = '0; pcm_data = '0; irq_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_we", 32'(buf_we), 32'd0);
        chk("rst_adr", 32'(buf_adr), 32'd0);
        chk("rst_dat", 32'(buf_dat), 32'd0);
        chk("rst_rdy", 32'(ready_bank), 32'd0);
        chk_flags("rst", 0, 0, 0);

        // First bank: 32 in-order samples to adr 0..31
        rst = 1'b0; enable = 1'b1;
        cycle(1'b0, 0, 0, 1'b0);               // IDLE -> SYNC
        for (int n = 0; n < 32; n++) begin
            wr(n % 8, 16'h100 + n, n, 1'b0);
            if (n == 30) chk("irq_pre", 32'(irq), 32'd0);
        end
        chk("b0_irq", 32'(irq), 32'd1);
        chk("b0_rdy", 32'(ready_bank), 32'd0);
        chk("b0_ovf", 32'(overflow), 32'd0);

        // Second bank with no ack: overflow on completion
        for (int n = 32; n < 64; n++) wr(n % 8, 16'h100 + n, n, 1'b0);
        chk("b1_irq", 32'(irq), 32'd1);
        chk("b1_rdy", 32'(ready_bank), 32'd1);
        chk("b1_ovf", 32'(overflow), 32'd1);
`ifdef MIC_BUF_OVFCNT_EN
        chk("b1_ocnt", 32'(ovf_count), 32'd1);
`endif
        wr(0, 16'h0140, 0, 1'b0);               // wraps back to bank 0

        // Channel glitch 0,1,2,5 at sample 0
        wr(1, 16'h0201, 1, 1'b0);
        wr(2, 16'h0202, 2, 1'b0);
        drop(5, "glitch_drop");
        chk("glitch_ferr", 32'(frame_err), 32'd1);
        drop(3, "sync_drop3");
        drop(1, "sync_drop1");
        for (int n = 0; n < 13; n++) wr(n % 8, 16'h300 + n, n, 1'b0);
        chk_flags("pre_drop", 1, 1, 1);

        // Enable drop with a coincident pcm_valid: sample dropped, flags cleared
        enable = 1'b0;
        drop(5, "en_drop");
        chk_flags("idle", 0, 0, 0);
`ifdef MIC_BUF_OVFCNT_EN
        chk("idle_ocnt", 32'(ovf_count), 32'd0);
`endif
        drop(0, "idle_drop");

        // Re-enable restarts at adr 0, then ack exactly at the 2nd completion
        enable = 1'b1;
        cycle(1'b0, 0, 0, 1'b0);
        for (int n = 0; n < 32; n++) wr(n % 8, 16'h400 + n, n, 1'b0);
        chk("ack_b0_irq", 32'(irq), 32'd1);
        for (int n = 32; n < 64; n++) wr(n % 8, 16'h400 + n, n, n == 63);
        chk_flags("ack_same", 1, 0, 0);
        chk("ack_rdy", 32'(ready_bank), 32'd1);
`ifdef MIC_BUF_OVFCNT_EN
        chk("ack_ocnt", 32'(ovf_count), 32'd0);
`endif
        cycle(1'b0, 0, 0, 1'b1);
        chk("ack_clr_irq", 32'(irq), 32'd0);

        // Reset mid-bank with pcm_valid high
        wr(0, 16'h0500, 0, 1'b0);
        wr(1, 16'h0501, 1, 1'b0);
        rst = 1'b1;
        cycle(1'b1, 2, 16'h0502, 1'b0);
        chk("mrst_we", 32'(buf_we), 32'd0);
        chk("mrst_adr", 32'(buf_adr), 32'd0);
        chk("mrst_dat", 32'(buf_dat), 32'd0);
        chk("mrst_rdy", 32'(ready_bank), 32'd0);
        chk_flags("mrst", 0, 0, 0);
`ifdef MIC_BUF_OVFCNT_EN
        chk("mrst_ocnt", 32'(ovf_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
